pingpong_ring_counter: RTL

PINGPONG_RING_COUNTER -- requirements
Module: pingpong_ring_counter

---
 rtl/pingpong_pkg.sv | 9 +
 rtl/pingpong_ring_counter.sv | 98 +++++++++
 2 files changed

// File: rtl/pingpong_pkg.sv
// pingpong_pkg: mode encoding shared by pingpong_ring_counter and its users
package pingpong_pkg;
  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROT_UP = 2'b01,
    MODE_ROT_DN = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;
endpackage

// File: rtl/pingpong_ring_counter.sv
// pingpong_ring_counter: one-hot ring/bounce counter with end-of-travel dwell and turn pulse
//   clk, reset (sync, active-high), en (step enable), mode (bounce/rot-up/rot-down/hold),
//   load/load_pos (clamped position load, beats en), count (one-hot), pos (binary index),
//   dir (0 toward MSB), at_end (pos at either end), turn (pulse after reversal or wrap)
module pingpong_ring_counter
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DWELL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     load,
  input  logic [$clog2(WIDTH)-1:0] load_pos,
  output logic [WIDTH-1:0]         count,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     dir,
  output logic                     at_end,
  output logic                     turn
);
  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;
  logic [7:0]    dwell_q, dwell_d;
  logic          turn_q, turn_d;
  mode_t         mode_q, mode_d;
  logic [7:0]    dw;
  logic          rev;
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= '0;
      dir_q   <= 1'b0;
      dwell_q <= '0;
      turn_q  <= 1'b0;
      mode_q  <= mode_d;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      turn_q  <= turn_d;
      mode_q  <= mode_d;
    end
  end
  // a mode change restarts any dwell in progress
  always_comb begin
    mode_d  = mode_t'(mode);
    dw      = (mode_d != mode_q) ? '0 : dwell_q;
    rev     = dir_q ? (pos_q == '0) : (pos_q == LAST);
    pos_d   = pos_q;
    dir_d   = dir_q;
    dwell_d = dw;
    turn_d  = 1'b0;
    if (load) begin
      pos_d   = (int'(load_pos) > WIDTH - 1) ? LAST : load_pos;
      dwell_d = '0;
    end else if (en) begin
      case (mode_d)
        MODE_ROT_UP: begin
          dir_d   = 1'b0;
          pos_d   = (pos_q == LAST) ? '0 : pos_q + 1'b1;
          turn_d  = (pos_q == LAST);
          dwell_d = '0;
        end
        MODE_ROT_DN: begin
          dir_d   = 1'b1;
          pos_d   = (pos_q == '0) ? LAST : pos_q - 1'b1;
          turn_d  = (pos_q == '0);
          dwell_d = '0;
        end
        MODE_HOLD: dwell_d = '0;
        default: begin
          if (!rev) begin
            pos_d   = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
            dwell_d = '0;
          end else if (int'(dw) >= DWELL) begin
            dir_d   = ~dir_q;
            pos_d   = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
            turn_d  = 1'b1;
            dwell_d = '0;
          end else begin
            dwell_d = dw + 8'd1;
          end
        end
      endcase
    end
  end
  always_comb begin
    count        = '0;
    count[pos_q] = 1'b1;
    at_end       = (pos_q == '0) || (pos_q == LAST);
  end
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign turn = turn_q;
endmodule
